// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, S-boxes, key schedules and FSM states.
// Bit numbering is MSB-first ([0:N-1]); table entries are 1-based source bit positions.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } des_state_e;

  localparam logic [6:0] IP_T [0:63] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};

  localparam logic [6:0] FP_T [0:63] = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32, 7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30, 7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28, 7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26, 7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};

  localparam logic [6:0] E_T [0:47] = '{
    7'd32, 7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  7'd9,  7'd8,  7'd9,  7'd10, 7'd11,
    7'd12, 7'd13, 7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17, 7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd20, 7'd21,
    7'd22, 7'd23, 7'd24, 7'd25, 7'd24, 7'd25, 7'd26, 7'd27, 7'd28, 7'd29, 7'd28, 7'd29, 7'd30, 7'd31, 7'd32, 7'd1};

  localparam logic [6:0] P_T [0:31] = '{
    7'd16, 7'd7,  7'd20, 7'd21, 7'd29, 7'd12, 7'd28, 7'd17, 7'd1,  7'd15, 7'd23, 7'd26, 7'd5,  7'd18, 7'd31, 7'd10,
    7'd2,  7'd8,  7'd24, 7'd14, 7'd32, 7'd27, 7'd3,  7'd9,  7'd19, 7'd13, 7'd30, 7'd6,  7'd22, 7'd11, 7'd4,  7'd25};

  localparam logic [6:0] PC1_T [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};

  localparam logic [6:0] PC2_T [0:47] = '{
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,  7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10, 7'd23, 7'd19, 7'd12, 7'd4,
    7'd26, 7'd8,  7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,  7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55, 7'd30, 7'd40,
    7'd51, 7'd45, 7'd33, 7'd48, 7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53, 7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32};

  // Encrypt rotates left by LS_T; decrypt walks back with RS_T (round 1 reuses C0/D0 for K16).
  localparam logic [1:0] LS_T [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] RS_T [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Each S-box: 64 nibbles, row-major (row*16+col), first hex digit is entry 0.
  localparam logic [255:0] SBOX_T [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [0:63] ip_perm(input logic [0:63] x);
    logic [0:63] y;
    logic [5:0]  j;
    y = 64'd0;
    for (int i = 0; i < 64; i++) begin
      j    = 6'(IP_T[i] - 7'd1);
      y[i] = x[j];
    end
    return y;
  endfunction

  function automatic logic [0:63] fp_perm(input logic [0:63] x);
    logic [0:63] y;
    logic [5:0]  j;
    y = 64'd0;
    for (int i = 0; i < 64; i++) begin
      j    = 6'(FP_T[i] - 7'd1);
      y[i] = x[j];
    end
    return y;
  endfunction

  function automatic logic [0:47] e_perm(input logic [0:31] x);
    logic [0:47] y;
    logic [4:0]  j;
    y = 48'd0;
    for (int i = 0; i < 48; i++) begin
      j    = 5'(E_T[i] - 7'd1);
      y[i] = x[j];
    end
    return y;
  endfunction

  function automatic logic [0:31] p_perm(input logic [0:31] x);
    logic [0:31] y;
    logic [4:0]  j;
    y = 32'd0;
    for (int i = 0; i < 32; i++) begin
      j    = 5'(P_T[i] - 7'd1);
      y[i] = x[j];
    end
    return y;
  endfunction

  function automatic logic [0:55] pc1_perm(input logic [0:63] x);
    logic [0:55] y;
    logic [5:0]  j;
    y = 56'd0;
    for (int i = 0; i < 56; i++) begin
      j    = 6'(PC1_T[i] - 7'd1);
      y[i] = x[j];
    end
    return y;
  endfunction

  function automatic logic [0:47] pc2_perm(input logic [0:55] x);
    logic [0:47] y;
    logic [5:0]  j;
    y = 48'd0;
    for (int i = 0; i < 48; i++) begin
      j    = 6'(PC2_T[i] - 7'd1);
      y[i] = x[j];
    end
    return y;
  endfunction

  function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[27], x[0:26]};
      2'd2:    return {x[26:27], x[0:25]};
      default: return x;
    endcase
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
    logic [5:0] idx;
    idx = {b[5], b[0], b[4:1]};
    return SBOX_T[n][{6'd63 - idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R,K): expansion, subkey xor, eight S-boxes, P permutation.
module des_f
  import des_pkg::*;
(
  input  logic [0:31] r,
  input  logic [0:47] k,
  output logic [0:31] f
);

  logic [0:47] x_s;
  logic [0:31] s_s;

  // Expand, mix in the subkey and substitute six bits at a time
  always_comb begin
    x_s = e_perm(r) ^ k;
    s_s = 32'd0;
    for (int j = 0; j < 8; j++) begin
      s_s[4*j +: 4] = sbox(3'(j), x_s[6*j +: 6]);
    end
  end

  assign f = p_perm(s_s);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per enabled clock, subkeys generated
// on the fly by rotating C/D right so K16 is used first and K1 last.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] cyphertext,
  input  logic [0:63] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] plaintext,
  output logic        busy
);

  des_state_e  state_r;
  logic [4:0]  rnd_r;
  logic [0:31] l_r;
  logic [0:31] r_r;
  logic [0:27] c_r;
  logic [0:27] d_r;
  logic [0:63] plaintext_r;
  logic        out_valid_r;
  logic        busy_r;

  logic [1:0]  rs_s;
  logic [0:27] c_rot_s;
  logic [0:27] d_rot_s;
  logic [0:47] k_s;
  logic [0:31] f_s;
  logic [0:31] r_new_s;
  logic [0:63] ip_s;
  logic [0:55] pc1_s;
  logic        in_ready_s;
  logic        accept_s;

  // Subkey for the current round and the input-side permutations
  always_comb begin
    rs_s    = RS_T[4'(rnd_r - 5'd1)];
    c_rot_s = rotr28(c_r, rs_s);
    d_rot_s = rotr28(d_r, rs_s);
    k_s     = pc2_perm({c_rot_s, d_rot_s});
    ip_s    = ip_perm(cyphertext);
    pc1_s   = pc1_perm(key);
  end

  des_f u_f (
    .r (r_r),
    .k (k_s),
    .f (f_s)
  );

  // Round result and handshake acceptance; DONE frees the slot as the output leaves
  always_comb begin
    r_new_s = l_r ^ f_s;
    case (state_r)
      IDLE:    in_ready_s = en;
      DONE:    in_ready_s = en & out_ready;
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_ready_s & in_valid;
  end

  // FSM, round counter, datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rnd_r       <= 5'd0;
      l_r         <= 32'd0;
      r_r         <= 32'd0;
      c_r         <= 28'd0;
      d_r         <= 28'd0;
      plaintext_r <= 64'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (en) begin
      if (accept_s) begin
        l_r         <= ip_s[0:31];
        r_r         <= ip_s[32:63];
        c_r         <= pc1_s[0:27];
        d_r         <= pc1_s[28:55];
        rnd_r       <= 5'd1;
        state_r     <= ROUND;
        busy_r      <= 1'b1;
        out_valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          ROUND: begin
            c_r <= c_rot_s;
            d_r <= d_rot_s;
            l_r <= r_r;
            r_r <= r_new_s;
            if (rnd_r == 5'd16) begin
              // Final swap is undone: FP takes R16||L16
              plaintext_r <= fp_perm({r_new_s, r_r});
              out_valid_r <= 1'b1;
              busy_r      <= 1'b0;
              rnd_r       <= 5'd0;
              state_r     <= DONE;
            end else begin
              rnd_r <= rnd_r + 5'd1;
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid_r <= 1'b0;
              state_r     <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign plaintext = plaintext_r;
  assign busy      = busy_r;

endmodule

// File: doc/des_decrypt_iter.md
Name: des_decrypt_iter

Overview:
Iterative DES decryptor: the inverse-direction companion to the pipelined DES encryptor. It takes a 64-bit ciphertext and a 64-bit key through a valid/ready handshake. It executes the 16 Feistel rounds one per clock with the reversed key schedule, then presents the 64-bit plaintext through a second valid/ready handshake. It shares the encryptor's bit numbering and enable semantics, so the two can be chained for round-trip checks.

Parameters:
- none. DES geometry is fixed; all tables come from des_pkg.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  global advance enable; low freezes all state
- in_valid  input  1  cyphertext/key presented
- in_ready  output  1  block can accept a new cyphertext/key
- cyphertext  input  [0:63]  ciphertext; bit 0 is DES bit 1 (MSB)
- key  input  [0:63]  DES key; parity bits 7,15,...,63 are ignored
- out_valid  output  1  plaintext valid
- out_ready  input  1  downstream accepts plaintext
- plaintext  output  [0:63]  decrypted block, same numbering as cyphertext
- busy  output  1  rounds in progress (state ROUND)

Behaviour:
- States:
  - IDLE: in_ready=1 when en=1.
  - ROUND: counter rnd 1..16.
  - DONE: out_valid=1.
- Async reset (reset_n=0): state=IDLE, rnd=0, L/R/C/D registers=0, plaintext=0, out_valid=0, busy=0. An in-flight block is discarded, with no partial output.
- en=0: no register changes, in_ready forced 0, out_valid holds its value, plaintext holds. A handshake never completes while en=0.
- Accept (edge where en & in_valid & in_ready):
  - L||R <= IP(cyphertext)
  - C||D <= PC1(key)
  - rnd <= 1, state <= ROUND
  - Inputs are sampled only at this edge; later changes are ignored.
- ROUND, each en-qualified edge:
  - Rotate C and D right by rs[rnd], with rs = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rnd 1..16.
  - Subkey K = PC2(rotated C||D), so the round uses K16 first and K1 last.
  - L <= R; R <= L xor f(R,K).
  - rnd increments.
- rnd==16 edge:
  - plaintext <= FP(R_new||L_new), i.e. the swap is undone before FP.
  - out_valid <= 1, state <= DONE.
- Latency: out_valid is first high exactly 16 en-active cycles after the accept edge.
- Throughput: one block per 17 cycles; back-to-back gives 16+1.
- DONE:
  - plaintext and out_valid stay stable while out_ready=0 (no drop, no change).
  - Edge with en & out_ready: out_valid <= 0.
  - If in_valid is also high at that edge, the new block is accepted on the same edge (in_ready = out_ready in DONE) and state goes to ROUND.
  - Otherwise state goes to IDLE.
- in_ready is combinational: en & (state==IDLE | (state==DONE & out_ready)). out_valid is registered.
- in_valid while busy: ignored, in_ready=0, the source must hold.

Decomposition:
- des_pkg, shared with the encryptor, holds:
  - IP, FP, E, P, PC1 and PC2 permutation tables
  - the 8 S-box tables
  - the encrypt left-shift schedule and the decrypt right-shift schedule (rs)
  - state enum {IDLE, ROUND, DONE}
- Sub-module des_f (combinational f-function: E expansion, xor with 48-bit subkey, S-boxes, P), reused from/with the encryptor rounds.
- The top holds the FSM, counter, L/R/C/D registers and the handshake.

Test Plan:
- Known answer:
  - key=0e329232ea6d0d73, cyphertext=0000000000000000 -> plaintext=8787878787878787 at 16 cycles after accept.
  - key=133457799bbcdff1, cyphertext=85e813540f0ab405 -> 0123456789abcdef.
- Back-to-back, out_ready=1, in_valid held:
  - Block 1: key=AAAAAAAAAAAAAAAA, ct=C4322BE19E9A5A17 -> AAAAAAAAAAAAAAAA.
  - Block 2: key=0, ct=8CA64DE9C1B123A7 -> 0000000000000000.
  - Required: second accept on the same edge as the first output handshake; outputs 17 cycles apart.
- Backpressure:
  - Stimulus: key=FFFFFFFFFFFFFFFF, ct=7359B2163E4EDC58, out_ready=0 for 10 cycles.
  - Required: plaintext=FFFFFFFFFFFFFFFF stable, out_valid=1, in_ready=0 throughout; out_valid drops 1 cycle after out_ready=1.
- Enable pause:
  - Stimulus: deassert en for 20 cycles at rnd=5 with key=5555555555555555, ct=3BCDD41E6165A5E8.
  - Required: result 5555555555555555 after 16 en-active cycles total; no output change during the pause.
- Reset mid-operation:
  - Stimulus: reset_n low at rnd=8.
  - Required: out_valid=0, plaintext=0, in_ready=1 immediately (async), busy=0; the next block decrypts correctly.
- Round trip: encryptor output fed directly to des_decrypt_iter with the same key over 100 random blocks -> plaintext equals the original input for every block; key parity bits randomised with no effect.
